// File: rtl/field_mul_pkg.sv
// Shared constants and elaboration helpers for the GF(2^W - C) multiplier.
package field_mul_pkg;

  localparam int unsigned W_DEF = 255;
  localparam int unsigned C_DEF = 19;
  localparam int unsigned LAT   = 5;
  localparam int unsigned MAXW  = 512;

  function automatic logic [MAXW-1:0] p_of(input int unsigned w, input int unsigned c);
    return (MAXW'(1) << w) - MAXW'(c);
  endfunction

  // Two folds land below 2p only when C^2 + 2C < 2^W.
  function automatic bit c_ok(input int unsigned w, input int unsigned c);
    logic [MAXW-1:0] cc;
    cc = MAXW'(c);
    return (c >= 1) && ((cc * cc + (cc << 1)) < (MAXW'(1) << w));
  endfunction

endpackage

// File: rtl/karatsuba_mul.sv
// One-level Karatsuba W x W unsigned multiplier, three stages, shared enable.
module karatsuba_mul
  import field_mul_pkg::*;
#(
  parameter int unsigned W     = W_DEF,
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             vld_i,
  input  logic [W-1:0]     a_i,
  input  logic [W-1:0]     b_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             vld_o,
  output logic [TAG_W-1:0] tag_o,
  output logic [2*W-1:0]   prod_o
);

  localparam int unsigned H   = (W + 1) / 2;
  localparam int unsigned H1  = H + 1;
  localparam int unsigned H2  = 2 * H;
  localparam int unsigned MW  = 2 * H + 2;
  localparam int unsigned PW  = 2 * W;

  logic [H-1:0]     ah_d, bh_d;
  logic [H:0]       as_d, bs_d;
  logic [H-1:0]     ah_p0_q, al_p0_q, bh_p0_q, bl_p0_q;
  logic [H:0]       as_p0_q, bs_p0_q;
  logic [TAG_W-1:0] tag_p0_q, tag_p1_q, tag_p2_q;
  logic             vld_p0_q, vld_p1_q, vld_p2_q;
  logic [H2-1:0]    hh_p1_q, ll_p1_q;
  logic [MW-1:0]    mm_p1_q;
  logic [PW-1:0]    hh_x, ll_x, mm_x, prod_d, prod_p2_q;

  assign ah_d = H'(a_i[W-1:H]);
  assign bh_d = H'(b_i[W-1:H]);
  assign as_d = H1'(ah_d) + H1'(a_i[H-1:0]);
  assign bs_d = H1'(bh_d) + H1'(b_i[H-1:0]);

  // Recombination runs modulo 2^(2W); the true product always fits.
  assign hh_x   = PW'(hh_p1_q);
  assign ll_x   = PW'(ll_p1_q);
  assign mm_x   = PW'(mm_p1_q);
  assign prod_d = (hh_x << H2) + ((mm_x - hh_x - ll_x) << H) + ll_x;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p0_q <= 1'b0;
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
    end else if (en_i) begin
      vld_p0_q <= vld_i;
      vld_p1_q <= vld_p0_q;
      vld_p2_q <= vld_p1_q;
    end
  end

  always_ff @(posedge clk) begin
    if (en_i) begin
      // S0: split operands and form half-sums
      ah_p0_q   <= ah_d;
      al_p0_q   <= a_i[H-1:0];
      bh_p0_q   <= bh_d;
      bl_p0_q   <= b_i[H-1:0];
      as_p0_q   <= as_d;
      bs_p0_q   <= bs_d;
      tag_p0_q  <= tag_i;
      // S1: three sub-products
      hh_p1_q   <= H2'(ah_p0_q) * H2'(bh_p0_q);
      ll_p1_q   <= H2'(al_p0_q) * H2'(bl_p0_q);
      mm_p1_q   <= MW'(as_p0_q) * MW'(bs_p0_q);
      tag_p1_q  <= tag_p0_q;
      // S2: full 2W-bit product
      prod_p2_q <= prod_d;
      tag_p2_q  <= tag_p1_q;
    end
  end

  assign vld_o  = vld_p2_q;
  assign tag_o  = tag_p2_q;
  assign prod_o = prod_p2_q;

endmodule

// File: rtl/field_mul_pipe.sv
// Pipelined (a*b) mod (2^W - C) with canonical result, valid/ready and tag.
module field_mul_pipe
  import field_mul_pkg::*;
#(
  parameter int unsigned W     = W_DEF,
  parameter int unsigned C     = C_DEF,
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sq,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_res,
  output logic [TAG_W-1:0] out_tag
);

  localparam int unsigned CW  = $clog2(C + 1);
  localparam int unsigned F1W = W + CW;
  localparam int unsigned W1  = W + 1;
  localparam logic [W:0]  P   = W1'(p_of(W, C));

  if (!c_ok(W, C)) begin : g_bad_c
    $error("field_mul_pipe: C outside 1 <= C, C*C + 2*C < 2^W");
  end

  function automatic logic [F1W-1:0] fold1(input logic [2*W-1:0] p);
    return F1W'(p[2*W-1:W]) * F1W'(C) + F1W'(p[W-1:0]);
  endfunction

  function automatic logic [W:0] fold2(input logic [F1W-1:0] f);
    return W1'(f[F1W-1:W]) * W1'(C) + W1'(f[W-1:0]);
  endfunction

  function automatic logic [W-1:0] canon(input logic [W:0] x);
    logic [W:0] d;
    d = x - P;
    return (x >= P) ? d[W-1:0] : x[W-1:0];
  endfunction

  logic             adv;
  logic [W-1:0]     b_sel;
  logic             vld_p2;
  logic [TAG_W-1:0] tag_p2;
  logic [2*W-1:0]   prod_p2;
  logic             vld_p3_q, vld_p4_q;
  logic [TAG_W-1:0] tag_p3_q, tag_p4_q;
  logic [W:0]       f2_p3_q;
  logic [W-1:0]     res_p4_q;

  // One enable for every stage: a stalled output freezes the whole pipe.
  assign adv      = !vld_p4_q || out_ready;
  assign in_ready = adv || !rst_n;
  assign b_sel    = in_sq ? in_a : in_b;

  karatsuba_mul #(.W(W), .TAG_W(TAG_W)) u_kmul (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (adv),
    .vld_i  (in_valid),
    .a_i    (in_a),
    .b_i    (b_sel),
    .tag_i  (in_tag),
    .vld_o  (vld_p2),
    .tag_o  (tag_p2),
    .prod_o (prod_p2)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p3_q <= 1'b0;
      vld_p4_q <= 1'b0;
      res_p4_q <= '0;
      tag_p4_q <= '0;
    end else if (adv) begin
      vld_p3_q <= vld_p2;
      // S4: conditional subtract into the output register
      vld_p4_q <= vld_p3_q;
      res_p4_q <= canon(f2_p3_q);
      tag_p4_q <= tag_p3_q;
    end
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      // S3: both folds bring the product below 2p
      f2_p3_q  <= fold2(fold1(prod_p2));
      tag_p3_q <= tag_p2;
    end
  end

  assign out_valid = vld_p4_q;
  assign out_res   = res_p4_q;
  assign out_tag   = tag_p4_q;

endmodule

// File: tb/tb_field_mul_pipe.sv
// Directed table for W=255/C=19 plus stall, reset and random W=16/C=15 runs.
module tb_field_mul_pipe;
  import field_mul_pkg::*;

  localparam int W  = 255;
  localparam int TW = 4;
  localparam logic [W-1:0] P = {{247{1'b1}}, 8'hED};
  localparam int unsigned P16 = 65521;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, in_valid, in_ready, in_sq, out_valid, out_ready;
  logic [W-1:0]  in_a, in_b, out_res, drv_exp;
  logic [TW-1:0] in_tag, out_tag;

  logic          rst16_n, v16, r16, sq16, ov16, or16;
  logic [15:0]   a16, b16, res16, exp16;
  logic [TW-1:0] tag16, otag16;

  int total = 0;
  int bad   = 0;

  field_mul_pipe #(.W(255), .C(19), .TAG_W(TW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_sq(in_sq), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res), .out_tag(out_tag)
  );

  field_mul_pipe #(.W(16), .C(15), .TAG_W(TW)) dut16 (
    .clk(clk), .rst_n(rst16_n), .in_valid(v16), .in_ready(r16),
    .in_sq(sq16), .in_a(a16), .in_b(b16), .in_tag(tag16),
    .out_valid(ov16), .out_ready(or16), .out_res(res16), .out_tag(otag16)
  );

  typedef struct {
    logic         sq;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
  } vec_t;

  typedef struct {
    logic [W-1:0]  res;
    logic [TW-1:0] tag;
  } exp_t;

  exp_t expq[$];
  exp_t q16[$];
  int   recv16 = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic sq, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [TW-1:0] tag, input logic [W-1:0] e);
    in_valid = 1'b1; in_sq = sq; in_a = a; in_b = b; in_tag = tag; drv_exp = e;
  endtask

  task automatic issue(input logic sq, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [TW-1:0] tag, input logic [W-1:0] e);
    logic acc;
    acc = 1'b0;
    drive(sq, a, b, tag, e);
    for (int k = 0; k < 200 && !acc; k++) begin
      @(negedge clk);
      acc = in_ready && rst_n;
      tick();
    end
    if (!acc) chk("issue_timeout", 0, 1);
  endtask

  function automatic logic [15:0] model16(input logic sq, input logic [15:0] a, input logic [15:0] b);
    longint unsigned x, y;
    x = 64'(a);
    y = sq ? 64'(a) : 64'(b);
    return 16'((x * y) % 64'(P16));
  endfunction

  // Scoreboards: accepted ops queue their expected result; transfers pop it.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && in_valid && in_ready) begin
      e.res = drv_exp; e.tag = in_tag;
      expq.push_back(e);
    end
    if (rst_n && out_valid && out_ready) begin
      if (expq.size() == 0) chk("unexpected_out_tag", 256'(out_tag), 256'hFFFF);
      else begin
        e = expq.pop_front();
        chk("out_res", out_res, e.res);
        chk("out_tag", out_tag, e.tag);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst16_n && v16 && r16) begin
      e.res = W'(exp16); e.tag = tag16;
      q16.push_back(e);
    end
    if (rst16_n && ov16 && or16) begin
      recv16++;
      chk("w16_lt_p", res16 < 16'(P16), 1);
      if (q16.size() == 0) chk("w16_unexpected_tag", 256'(otag16), 256'hFFFF);
      else begin
        e = q16.pop_front();
        chk("w16_res", res16, e.res);
        chk("w16_tag", otag16, e.tag);
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t         vt[12];
    logic [W-1:0] ones, pw254, pw128, pw127, held_res, ea, eb;
    logic [TW-1:0] held_tag;
    logic         early, seen, got, stall_bad;
    logic         done16;

    ones  = '1;
    pw254 = W'(1) << 254;
    pw128 = W'(1) << 128;
    pw127 = W'(1) << 127;
    vt[0]  = '{1'b0, W'(9),  W'(11), W'(99)};
    vt[1]  = '{1'b0, W'(25), W'(35), W'(875)};
    vt[2]  = '{1'b0, pw254,  W'(2),  W'(19)};
    vt[3]  = '{1'b0, ones,   W'(1),  W'(18)};
    vt[4]  = '{1'b0, P - 1,  P - 1,  W'(1)};
    vt[5]  = '{1'b1, P - 1,  W'(0),  W'(1)};
    vt[6]  = '{1'b0, P,      W'(5),  W'(0)};
    vt[7]  = '{1'b0, ones,   ones,   W'(324)};
    vt[8]  = '{1'b0, W'(0),  ones,   W'(0)};
    vt[9]  = '{1'b1, W'(3),  W'(7),  W'(9)};
    vt[10] = '{1'b0, pw128,  pw127,  W'(19)};
    vt[11] = '{1'b0, P - 1,  W'(2),  P - 2};

    rst_n = 1'b0; in_valid = 1'b0; in_sq = 1'b0; in_a = '0; in_b = '0; in_tag = '0;
    drv_exp = '0; out_ready = 1'b1;
    rst16_n = 1'b0; v16 = 1'b0; sq16 = 1'b0; a16 = '0; b16 = '0; tag16 = '0; exp16 = '0;
    or16 = 1'b1; done16 = 1'b0;

    // Reset state; an op presented while rst_n is low must be dropped.
    tick(); tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_res", out_res, 0);
    chk("rst_out_tag", out_tag, 0);
    chk("rst_in_ready", in_ready, 1);
    drive(0, W'(1), W'(1), 4'd5, W'(1));
    tick();
    rst_n = 1'b1; in_valid = 1'b0;
    chk("in_ready_after_rst", in_ready, 1);
    seen = 1'b0;
    for (int k = 0; k < 7; k++) begin seen |= out_valid; tick(); end
    chk("op_in_reset_dropped", seen, 0);

    // Latency: accepted at e0, visible after e4; next op one cycle later.
    drive(vt[0].sq, vt[0].a, vt[0].b, 4'd1, vt[0].exp);
    tick();
    drive(vt[1].sq, vt[1].a, vt[1].b, 4'd2, vt[1].exp);
    tick();
    in_valid = 1'b0;
    early = out_valid; tick();
    early |= out_valid; tick();
    early |= out_valid;
    chk("lat_not_early", early, 0);
    tick();
    chk("lat_valid", out_valid, 1);
    chk("lat_res_99", out_res, 99);
    chk("lat_tag_1", out_tag, 1);
    tick();
    chk("next_valid", out_valid, 1);
    chk("next_res_875", out_res, 875);
    chk("next_tag_2", out_tag, 2);
    tick();
    chk("lat_idle", out_valid, 0);

    // Directed table streamed back-to-back.
    for (int i = 0; i < 12; i++) issue(vt[i].sq, vt[i].a, vt[i].b, TW'(i), vt[i].exp);
    in_valid = 1'b0;
    for (int k = 0; k < 50 && (expq.size() != 0 || out_valid); k++) tick();
    chk("table_drained", expq.size(), 0);

    // Backpressure: 8 ops, output stalled 3 cycles at the first result.
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          ea = (i % 2 == 0) ? W'(i + 1) : P - W'(i + 1);
          eb = W'(i + 3);
          issue(1'b0, ea, eb, TW'(i),
                (i % 2 == 0) ? W'((i + 1) * (i + 3)) : P - W'((i + 1) * (i + 3)));
        end
        in_valid = 1'b0;
      end
      begin
        got = 1'b0;
        for (int k = 0; k < 50 && !got; k++) begin tick(); got = out_valid; end
        chk("bp_first_seen", got, 1);
        out_ready = 1'b0;
        held_res = out_res; held_tag = out_tag;
        chk("bp_first_tag", held_tag, 0);
        stall_bad = 1'b0;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          chk("bp_in_ready_low", in_ready, 0);
          stall_bad |= (out_valid !== 1'b1) || (out_res !== held_res) || (out_tag !== held_tag);
          tick();
        end
        chk("bp_output_stable", stall_bad, 0);
        out_ready = 1'b1;
      end
    join
    for (int k = 0; k < 50 && (expq.size() != 0 || out_valid); k++) tick();
    chk("bp_drained", expq.size(), 0);

    // Reset with three ops in flight.
    issue(1'b0, W'(2), W'(3), 4'd9,  W'(6));
    issue(1'b0, W'(4), W'(5), 4'd10, W'(20));
    issue(1'b0, W'(6), W'(8), 4'd11, W'(48));
    in_valid = 1'b0; rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    expq.delete();
    chk("midrst_out_valid", out_valid, 0);
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin seen |= out_valid; tick(); end
    chk("midrst_discarded", seen, 0);
    drive(1'b0, W'(6), W'(7), 4'd3, W'(42));
    tick();
    in_valid = 1'b0;
    early = out_valid; tick();
    early |= out_valid; tick();
    early |= out_valid; tick();
    early |= out_valid;
    chk("postrst_not_early", early, 0);
    tick();
    chk("postrst_valid", out_valid, 1);
    chk("postrst_res_42", out_res, 42);
    tick();

    // W=16, C=15: random operands, squaring and backpressure.
    tick();
    rst16_n = 1'b1;
    fork
      begin
        while (!done16) begin
          or16 = ($urandom_range(0, 3) != 0);
          tick();
        end
        or16 = 1'b1;
      end
      begin
        for (int n = 0; n < 10000; n++) begin
          logic acc;
          case ($urandom_range(0, 7))
            0: a16 = 16'hFFFF;
            1: a16 = 16'(P16 - 1);
            2: a16 = 16'(P16);
            default: a16 = 16'($urandom);
          endcase
          b16   = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
          sq16  = ($urandom_range(0, 3) == 0);
          tag16 = TW'(n);
          exp16 = model16(sq16, a16, b16);
          v16   = 1'b1;
          acc   = 1'b0;
          for (int k = 0; k < 200 && !acc; k++) begin
            @(negedge clk);
            acc = r16;
            tick();
          end
          if (!acc) chk("w16_issue_timeout", 0, 1);
          if ($urandom_range(0, 7) == 0) begin v16 = 1'b0; tick(); end
        end
        v16 = 1'b0;
        for (int k = 0; k < 500 && (q16.size() != 0 || ov16); k++) tick();
        done16 = 1'b1;
      end
    join
    chk("w16_drained", q16.size(), 0);
    chk("w16_count", recv16, 10000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
